// File: rtl/axi_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : axi_fifo_fwft
// Brief    : Valid/ready stream FIFO with first-word-fall-through output,
//            occupancy, almost-full/almost-empty flags and synchronous flush.
//            Define AXI_FIFO_HWM_EN to add the max_level high-water mark and
//            its hwm_clr input.
// Revision : 1.0 - initial release
// ============================================================================
module axi_fifo_fwft #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 5,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             rdy_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             rdy_out,
    output logic [LVL_W-1:0] level,
    output logic             almost_full,
    output logic             almost_empty
`ifdef AXI_FIFO_HWM_EN
    ,
    input  logic             hwm_clr,
    output logic [LVL_W-1:0] max_level
`endif
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [LVL_W-1:0]   c_lvl_full = LVL_W'(DEPTH);

    generate
        if (WIDTH < 1) begin : g_chk_width
            $error("axi_fifo_fwft: WIDTH must be >= 1");
        end
        if (DEPTH < 2) begin : g_chk_depth
            $error("axi_fifo_fwft: DEPTH must be >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
            $error("axi_fifo_fwft: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
            $error("axi_fifo_fwft: AE_THRESH must be in 0..DEPTH-1");
        end
    endgenerate

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_active;
    logic [LVL_W-1:0]   w_level_nxt;
    logic               w_push;
    logic               w_pop;

    // Pointers wrap explicitly so any DEPTH works, not just powers of two.
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    // rdy_in is purely registered state; a pop never frees a slot same-cycle.
    assign rdy_in       = r_active && !flush && (r_level < c_lvl_full);
    assign vld_out      = (r_level != '0);
    assign data_out     = r_mem[r_rd_ptr];
    assign level        = r_level;
    assign almost_full  = (r_level >= LVL_W'(AF_THRESH));
    assign almost_empty = (r_level <= LVL_W'(AE_THRESH));

    assign w_push = vld_in && rdy_in;
    assign w_pop  = vld_out && rdy_out && !flush;

    always_comb begin
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_active <= 1'b1;
            r_level  <= w_level_nxt;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
            end
        end
    end

    // Storage carries no reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

`ifdef AXI_FIFO_HWM_EN
    logic [LVL_W-1:0] r_max_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_level <= '0;
        end else if (hwm_clr) begin
            r_max_level <= '0;
        end else if (w_level_nxt > r_max_level) begin
            r_max_level <= w_level_nxt;
        end
    end

    assign max_level = r_max_level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_fifo_fwft
// Brief    : Directed vector bench for axi_fifo_fwft (WIDTH=64, DEPTH=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_fifo_fwft;

    localparam int WIDTH = 64;
    localparam int DEPTH = 5;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             vld_in;
    logic [WIDTH-1:0] data_in;
    logic             rdy_in;
    logic             vld_out;
    logic [WIDTH-1:0] data_out;
    logic             rdy_out;
    logic [LVL_W-1:0] level;
    logic             almost_full;
    logic             almost_empty;
`ifdef AXI_FIFO_HWM_EN
    logic             hwm_clr;
    logic [LVL_W-1:0] max_level;
`endif

    axi_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .vld_in       (vld_in),
        .data_in      (data_in),
        .rdy_in       (rdy_in),
        .vld_out      (vld_out),
        .data_out     (data_out),
        .rdy_out      (rdy_out),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef AXI_FIFO_HWM_EN
        ,
        .hwm_clr      (hwm_clr),
        .max_level    (max_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        vin;
        logic [63:0] din;
        logic        rout;
        logic        e_vld;
        logic        e_rdy;
        logic [2:0]  e_lvl;
        logic        e_af;
        logic        e_ae;
        logic        chk_d;
        logic [63:0] e_d;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic f, input logic vi, input logic [63:0] d,
                                input logic ro, input logic ev, input logic er,
                                input logic [2:0] el, input logic eaf, input logic eae,
                                input logic cd, input logic [63:0] ed);
        vec_t v;
        v.flush = f;  v.vin = vi;  v.din = d;  v.rout = ro;
        v.e_vld = ev; v.e_rdy = er; v.e_lvl = el;
        v.e_af = eaf; v.e_ae = eae; v.chk_d = cd; v.e_d = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic vi, input logic [63:0] d, input logic ro);
        flush   = f;
        vld_in  = vi;
        data_in = d;
        rdy_out = ro;
    endtask

    task automatic chk_state(input string nm, input logic ev, input logic er,
                             input logic [2:0] el, input logic eaf, input logic eae);
        chk({nm, ".vld_out"},      64'(vld_out),      64'(ev));
        chk({nm, ".rdy_in"},       64'(rdy_in),       64'(er));
        chk({nm, ".level"},        64'(level),        64'(el));
        chk({nm, ".almost_full"},  64'(almost_full),  64'(eaf));
        chk({nm, ".almost_empty"}, 64'(almost_empty), 64'(eae));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b0);
`ifdef AXI_FIFO_HWM_EN
        hwm_clr = 1'b0;
`endif

        // Fill to full, overfill attempt, drain, then single-word latency.
        tbl.push_back(mk(0, 1, 64'h1,  0, 1, 1, 3'd1, 0, 1, 1, 64'h1));
        tbl.push_back(mk(0, 1, 64'h2,  0, 1, 1, 3'd2, 0, 0, 1, 64'h1));
        tbl.push_back(mk(0, 1, 64'h3,  0, 1, 1, 3'd3, 0, 0, 1, 64'h1));
        tbl.push_back(mk(0, 1, 64'h4,  0, 1, 1, 3'd4, 1, 0, 1, 64'h1));
        tbl.push_back(mk(0, 1, 64'h5,  0, 1, 0, 3'd5, 1, 0, 1, 64'h1));
        tbl.push_back(mk(0, 1, 64'h66, 0, 1, 0, 3'd5, 1, 0, 1, 64'h1));
        tbl.push_back(mk(0, 0, 64'h0,  1, 1, 1, 3'd4, 1, 0, 1, 64'h2));
        tbl.push_back(mk(0, 0, 64'h0,  1, 1, 1, 3'd3, 0, 0, 1, 64'h3));
        tbl.push_back(mk(0, 0, 64'h0,  1, 1, 1, 3'd2, 0, 0, 1, 64'h4));
        tbl.push_back(mk(0, 0, 64'h0,  1, 1, 1, 3'd1, 0, 1, 1, 64'h5));
        tbl.push_back(mk(0, 0, 64'h0,  1, 0, 1, 3'd0, 0, 1, 0, 64'h0));
        tbl.push_back(mk(0, 1, 64'hAB, 1, 1, 1, 3'd1, 0, 1, 1, 64'hAB));
        tbl.push_back(mk(0, 0, 64'h0,  1, 0, 1, 3'd0, 0, 1, 0, 64'h0));

        #2;
        chk_state("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_state("post_reset", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(tbl[i].flush, tbl[i].vin, tbl[i].din, tbl[i].rout);
            step();
            chk_state(nm, tbl[i].e_vld, tbl[i].e_rdy, tbl[i].e_lvl, tbl[i].e_af, tbl[i].e_ae);
            if (tbl[i].chk_d) chk({nm, ".data_out"}, data_out, tbl[i].e_d);
        end
`ifdef AXI_FIFO_HWM_EN
        chk("hwm_after_fill", 64'(max_level), 64'd5);
`endif

        // Steady-state push+pop at level 2; pointers wrap several times.
        drive(1'b0, 1'b1, 64'h10, 1'b0); step();
        drive(1'b0, 1'b1, 64'h11, 1'b0); step();
        chk("stream.prefill_level", 64'(level), 64'd2);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 64'h12 + 64'(i), 1'b1);
            chk($sformatf("stream%0d.data_out", i), data_out, 64'h10 + 64'(i));
            step();
            chk($sformatf("stream%0d.level", i), 64'(level), 64'd2);
        end
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk("stream.tail0", data_out, 64'h24);
        step();
        chk("stream.tail1", data_out, 64'h25);
        step();
        chk_state("stream.drained", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);

        // Flush at level 3 overrides a simultaneous push and pop.
        drive(1'b0, 1'b1, 64'h31, 1'b0); step();
        drive(1'b0, 1'b1, 64'h32, 1'b0); step();
        drive(1'b0, 1'b1, 64'h33, 1'b0); step();
        chk("flush.pre_level", 64'(level), 64'd3);
        drive(1'b1, 1'b1, 64'h99, 1'b1);
        #1;
        chk("flush.rdy_in_during", 64'(rdy_in), 64'd0);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        #1;
        chk_state("flush.after", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 64'h44, 1'b0); step();
        chk("flush.repush_level", 64'(level), 64'd1);
        chk("flush.repush_data", data_out, 64'h44);
        drive(1'b0, 1'b0, 64'h0, 1'b1); step();
        chk("flush.empty_again", 64'(level), 64'd0);

        // Asynchronous reset between edges at level 4.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 64'h50 + 64'(i), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk_state("arst.pre", 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("arst.during", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
`ifdef AXI_FIFO_HWM_EN
        chk("arst.max_level", 64'(max_level), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_state("arst.release", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 64'h77, 1'b0); step();
        drive(1'b0, 1'b1, 64'h78, 1'b0); step();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk_state("arst.resume", 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        chk("arst.resume_data", data_out, 64'h77);
`ifdef AXI_FIFO_HWM_EN
        chk("hwm.resume", 64'(max_level), 64'd2);
        hwm_clr = 1'b1;
        step();
        hwm_clr = 1'b0;
        chk("hwm.clear", 64'(max_level), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
